// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR output capture buffer.
package fir_pkg;

   localparam int FIR_DATA_W  = 32;
   localparam int FIR_DEPTH   = 16;
   localparam int STATUS_ADDR = FIR_DEPTH;

   typedef enum logic {
      CAPTURE = 1'b0,
      DONE    = 1'b1
   } cap_state_t;

endpackage

// File: rtl/capture_ram.sv
// DEPTH x DATA_W sample store: one synchronous write port, one asynchronous read port.
module capture_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Read sees the pre-edge contents, so a same-cycle write shows up one cycle later.
   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fir_capture_buffer.sv
// Captures DEPTH filter output samples, then freezes until clear; exposes samples and status on a read map.
//   state   | meaning
//   CAPTURE | accepting samples into the next free entry
//   DONE    | DEPTH samples held, input refused until clear or reset
module fir_capture_buffer
   import fir_pkg::*;
#(
   parameter int DATA_W = FIR_DATA_W,
   parameter int DEPTH  = FIR_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [31:0]       regAddr,
   output logic [31:0]       regData,
   output logic              done
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   cap_state_t        state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              wr_en;
   logic [DATA_W-1:0] rd_data;
   logic [31:0]       rd_ext;
   logic [31:0]       status;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= CAPTURE;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      wr_en    = 1'b0;
      in_ready = (state_q == CAPTURE);
      done     = (state_q == DONE);
      if (clear) begin
         // Restart only; stored samples stay readable.
         state_d  = CAPTURE;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         case (state_q)
            CAPTURE: begin
               if (in_valid) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  count_d  = count_q + 1'b1;
                  if (count_q == CW'(DEPTH - 1)) state_d = DONE;
               end
            end
            DONE: begin
            end
            default: state_d = CAPTURE;
         endcase
      end
   end

   capture_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data (in_data),
      .rd_addr (regAddr[AW-1:0]),
      .rd_data (rd_data)
   );

   generate
      if (DATA_W >= 32) begin : g_trunc
         assign rd_ext = rd_data[31:0];
      end else begin : g_zext
         assign rd_ext = {{(32 - DATA_W){1'b0}}, rd_data};
      end
   endgenerate

   assign status = {done, 15'b0, 16'(count_q)};

   always_comb begin
      regData = '0;
      if (regAddr < 32'(DEPTH)) regData = rd_ext;
      else if (regAddr == 32'(DEPTH)) regData = status;
   end

endmodule

// File: tb/tb_fir_capture_buffer.sv
// Bench for fir_capture_buffer (DEPTH=8, DATA_W=32) against an array-based capture model.
module tb_fir_capture_buffer;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready;
   logic [31:0] regAddr = '0;
   logic [31:0] regData;
   logic        done;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] m_mem [DEPTH];
   int          m_count = 0;
   logic        m_done = 1'b0;

   fir_capture_buffer #(.DATA_W(32), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .regAddr  (regAddr),
      .regData  (regData),
      .done     (done)
   );

   always #50 clk = ~clk;

   function automatic logic [31:0] exp_read(input int a);
      if (a < DEPTH) return m_mem[a];
      if (a == DEPTH) return {m_done, 15'b0, 16'(m_count)};
      return 32'h0;
   endfunction

   // Behavioural capture model: fill entries in arrival order until full, then ignore input.
   task automatic model_edge(input logic r, input logic c, input logic v, input logic [31:0] d);
      if (r) begin
         for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
         m_count = 0;
         m_done  = 1'b0;
      end else if (c) begin
         m_count = 0;
         m_done  = 1'b0;
      end else if (v && !m_done) begin
         m_mem[m_count] = d;
         m_count++;
         if (m_count == DEPTH) m_done = 1'b1;
      end
   endtask

   task automatic cycle(input logic r, input logic c, input logic v, input logic [31:0] d);
      reset = r; clear = c; in_valid = v; in_data = d;
      @(posedge clk);
      model_edge(r, c, v, d);
      #1;
      reset = 1'b0; clear = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(posedge clk);
      model_edge(1'b1, 1'b0, 1'b0, '0);
      #1;
      n_vec++;
      if (in_ready !== 1'b1 || done !== 1'b0) begin
         n_err++; $display("FAIL reset_hold ready=%b done=%b exp 1/0", in_ready, done);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if (in_ready !== 1'b1 || done !== 1'b0) begin
         n_err++; $display("FAIL reset_after ready=%b done=%b exp 1/0", in_ready, done);
      end
      for (int a = 0; a <= DEPTH; a++) begin
         regAddr = a; #1;
         n_vec++;
         if (regData !== 32'h0) begin
            n_err++; $display("FAIL reset_read addr=%0d got %h exp 00000000", a, regData);
         end
      end
   endtask

   task automatic test_fill_freeze();
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b0, 1'b0, 1'b1, 32'h11 + i);
         n_vec++;
         if (done !== (i == DEPTH - 1)) begin
            n_err++; $display("FAIL fill_done after sample %0d got %b exp %b", i, done, (i == DEPTH - 1));
         end
      end
      for (int a = 0; a < DEPTH; a++) begin
         regAddr = a; #1;
         n_vec++;
         if (regData !== 32'h11 + a) begin
            n_err++; $display("FAIL fill_read addr=%0d got %h exp %h", a, regData, 32'h11 + a);
         end
      end
      regAddr = DEPTH; #1;
      n_vec++;
      if (regData !== 32'h8000_0008) begin
         n_err++; $display("FAIL fill_status got %h exp 80000008", regData);
      end
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL frozen_ready got %b exp 0", in_ready);
      end
      cycle(1'b0, 1'b0, 1'b1, 32'hFF);
      regAddr = 7; #1;
      n_vec++;
      if (regData !== 32'h18 || done !== 1'b1) begin
         n_err++; $display("FAIL frozen_entry7 got %h done=%b exp 00000018 done=1", regData, done);
      end
   endtask

   task automatic test_clear_collision();
      cycle(1'b0, 1'b1, 1'b1, 32'h55);
      regAddr = DEPTH; #1;
      n_vec++;
      if (done !== 1'b0 || regData !== 32'h0) begin
         n_err++; $display("FAIL clear_status done=%b status=%h exp 0/00000000", done, regData);
      end
      regAddr = 0; #1;
      n_vec++;
      if (regData !== 32'h11) begin
         n_err++; $display("FAIL clear_keeps_entry0 got %h exp 00000011", regData);
      end
      cycle(1'b0, 1'b0, 1'b1, 32'h66);
      regAddr = 0; #1;
      n_vec++;
      if (regData !== 32'h66) begin
         n_err++; $display("FAIL clear_next_sample got %h exp 00000066", regData);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 32'hC0 + i);
      cycle(1'b1, 1'b0, 1'b0, '0);
      n_vec++;
      if (in_ready !== 1'b1 || done !== 1'b0) begin
         n_err++; $display("FAIL midreset_flags ready=%b done=%b exp 1/0", in_ready, done);
      end
      for (int a = 0; a <= DEPTH; a++) begin
         regAddr = a; #1;
         n_vec++;
         if (regData !== 32'h0) begin
            n_err++; $display("FAIL midreset_read addr=%0d got %h exp 00000000", a, regData);
         end
      end
      regAddr = 32'h100; #1;
      n_vec++;
      if (regData !== 32'h0) begin
         n_err++; $display("FAIL out_of_range got %h exp 00000000", regData);
      end
   endtask

   task automatic test_gapped();
      logic [31:0] dat [4];
      dat[0] = 32'hA; dat[1] = 32'hB; dat[2] = 32'hC; dat[3] = 32'hD;
      // Old content is visible until the write edge.
      regAddr = 0; in_valid = 1'b1; in_data = dat[0]; #1;
      n_vec++;
      if (regData !== 32'h0) begin
         n_err++; $display("FAIL rdw_before got %h exp 00000000", regData);
      end
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b0, (i % 2 == 0), dat[i]);
         if (i == 0) begin
            n_vec++;
            if (regData !== 32'hA) begin
               n_err++; $display("FAIL rdw_after got %h exp 0000000a", regData);
            end
         end
      end
      regAddr = 0; #1;
      n_vec++;
      if (regData !== 32'hA) begin
         n_err++; $display("FAIL gapped_addr0 got %h exp 0000000a", regData);
      end
      regAddr = 1; #1;
      n_vec++;
      if (regData !== 32'hC) begin
         n_err++; $display("FAIL gapped_addr1 got %h exp 0000000c", regData);
      end
      regAddr = 2; #1;
      n_vec++;
      if (regData !== 32'h0) begin
         n_err++; $display("FAIL gapped_addr2 got %h exp 00000000", regData);
      end
      regAddr = DEPTH; #1;
      n_vec++;
      if (regData !== 32'h2) begin
         n_err++; $display("FAIL gapped_count got %h exp 00000002", regData);
      end
   endtask

   task automatic test_drain();
      logic [31:0] sent [$];
      int guard;
      cycle(1'b0, 1'b1, 1'b0, '0);
      guard = 0;
      while (sent.size() < DEPTH && guard < 100) begin
         logic        v;
         logic [31:0] d;
         v = ($urandom_range(0, 3) != 0);
         d = $urandom;
         if (v) sent.push_back(d);
         cycle(1'b0, 1'b0, v, d);
         guard++;
      end
      n_vec++;
      if (done !== 1'b1) begin
         n_err++; $display("FAIL drain_done got %b exp 1", done);
      end
      regAddr = 0;
      for (int i = 0; i < DEPTH && done; i++) begin
         #1;
         n_vec++;
         if (regData !== sent[i]) begin
            n_err++; $display("FAIL drain_seq idx=%0d got %h exp %h", i, regData, sent[i]);
         end
         @(posedge clk); #1;
         regAddr = regAddr + 1;
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         logic r, c, v;
         r = ($urandom_range(0, 59) == 0);
         c = ($urandom_range(0, 19) == 0);
         v = ($urandom_range(0, 2) != 0);
         cycle(r, c, v, $urandom);
         n_vec++;
         if (done !== m_done || in_ready !== !m_done) begin
            n_err++; $display("FAIL rand_flags n=%0d done=%b ready=%b exp done=%b", n, done, in_ready, m_done);
         end
         for (int a = 0; a <= DEPTH + 1; a++) begin
            regAddr = a; #1;
            n_vec++;
            if (regData !== exp_read(a)) begin
               n_err++; $display("FAIL rand_read n=%0d addr=%0d got %h exp %h", n, a, regData, exp_read(a));
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      @(negedge clk);
      test_reset();
      test_fill_freeze();
      test_clear_collision();
      test_reset_mid();
      test_gapped();
      test_drain();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog time limit reached, vectors=%0d", n_vec);
      $fatal(1);
   end

endmodule

// File: doc/fir_capture_buffer.md
FIR_CAPTURE_BUFFER -- requirements
Module: fir_capture_buffer

Interface
REQ-001 Parameter DATA_W, default 32: sample and read-data width.
REQ-002 Parameter DEPTH, default 16: number of captured samples; power of two, at least 2.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: reset, synchronous and active-high.
REQ-005 Port clear, input, 1: one-cycle pulse; restarts capture.
REQ-006 Port in_valid, input, 1: in_data holds a filter output sample.
REQ-007 Port in_data, input, DATA_W: filter output sample.
REQ-008 Port in_ready, output, 1: buffer accepts a sample this cycle.
REQ-009 Port regAddr, input, 32: read address.
REQ-010 Port regData, output, 32: read data, combinational from regAddr.
REQ-011 Port done, output, 1: DEPTH samples captured; buffer is frozen.

Function
REQ-012 States: CAPTURE, DONE.
REQ-013 A sample is accepted when in_valid && in_ready are both high.
REQ-014 CAPTURE behaviour:
- in_ready = 1.
- Each accepted sample is written to entry wr_ptr; then wr_ptr increments and count increments.
REQ-015 Acceptance when count == DEPTH-1:
- writes the last entry;
- next cycle: state = DONE, count = DEPTH, wr_ptr wraps to 0.
REQ-016 DONE behaviour:
- in_ready = 0 and done = 1;
- in_valid is ignored; no entry is modified.
REQ-017 clear in either state, next cycle:
- state = CAPTURE, wr_ptr = 0, count = 0, done = 0.
- Stored entries are not erased.
REQ-018 clear and an accepted sample in the same cycle: clear wins and the sample is discarded.
REQ-019 Read map (combinational, same cycle):
- regAddr < DEPTH: regData = entry[regAddr], zero-extended or truncated to 32 bits.
- regAddr == DEPTH: regData = {done, 15'b0, count[15:0]}.
- Any other regAddr: regData = 0.
REQ-020 Read-during-write: the read at the address being written returns the old content in that cycle and the new content from the next cycle.
REQ-021 count width is clog2(DEPTH)+1 and never exceeds DEPTH.
REQ-022 Reads have no side effects.
REQ-023 regAddr may change every cycle.
REQ-024 done is registered, so it is high exactly from the cycle after the final acceptance until clear or reset.

Reset
REQ-025 Values while reset is high and on the following cycle:
- state = CAPTURE, wr_ptr = 0, count = 0;
- done = 0, in_ready = 1.
REQ-026 Storage entries are reset to 0.
REQ-027 reset has priority over clear and in_valid.
REQ-028 reset in mid-capture discards partial progress.

Structure
REQ-029 Package fir_pkg holds:
- DATA_W and DEPTH defaults;
- the state enum cap_state_t {CAPTURE, DONE};
- the localparam STATUS_ADDR = DEPTH.
REQ-030 Storage is one sub-module, capture_ram:
- one synchronous write port;
- one asynchronous read port;
- DEPTH x DATA_W.
REQ-031 Control state, pointer, counter and the read-map multiplexing stay in fir_capture_buffer.

Verification (DEPTH=8, DATA_W=32)
REQ-032 Reset, then check outputs:
- in_ready=1, done=0;
- regAddr=8 gives regData=0x00000000;
- regAddr=0..7 give 0.
REQ-033 Fill and freeze:
- Stimulus: valid samples 0x11..0x18 on consecutive cycles.
- Response: done=1 on the cycle after 0x18; regAddr=0..7 read 0x11..0x18; regAddr=8 reads 0x80000008.
- A further sample 0xFF with in_valid is not stored; entry 7 stays 0x18.
REQ-034 Gapped input:
- Stimulus: in_valid toggling 1,0,1,0 with data 0xA,0xB,0xC,0xD.
- Response: only 0xA and 0xC are stored, at addresses 0 and 1; count reads 2.
REQ-035 Clear collision:
- Stimulus: in the DONE state, clear and in_valid (data 0x55) in the same cycle.
- Response: next cycle done=0 and count=0; entry 0 still holds its old value.
- The next accepted sample 0x66 lands at address 0.
REQ-036 Reset in mid-capture:
- Stimulus: after 3 samples, pulse reset for 1 cycle.
- Response: count=0, all entries 0, in_ready=1.
- Out-of-range regAddr=0x100 returns 0.
REQ-037 Testbench-style drain:
- Stimulus: the bench increments regAddr by 1 on each clock while done is high, starting from 0.
- Response: the sequence read back matches the input order exactly.
